// File: rtl/lc3b_pkg.sv
// Shared definitions for the LC-3b memory interface stage: FSM states,
// byte-enable encodings and the default ack timeout.
package lc3b_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   localparam logic [1:0] BE_WORD = 2'b11;
   localparam logic [1:0] BE_LO   = 2'b01;
   localparam logic [1:0] BE_HI   = 2'b10;

   localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/lc3b_byte_lane.sv
// Byte-lane steering between the 16-bit MDR and the word-wide memory:
// byte enables, store-data replication and sign-extended byte loads.
module lc3b_byte_lane
   import lc3b_pkg::*;
(
   input  logic        byte_i,
   input  logic        addr0_i,
   input  logic [15:0] wdata_i,
   input  logic [15:0] mem_rdata_i,
   output logic [1:0]  be_o,
   output logic [15:0] wdata_o,
   output logic [15:0] rdata_o
);

   logic [7:0] selByte;

   // Pick the addressed byte lane, then widen or replicate for byte accesses
   always_comb begin
      selByte = addr0_i ? mem_rdata_i[15:8] : mem_rdata_i[7:0];
      be_o    = BE_WORD;
      wdata_o = wdata_i;
      rdata_o = mem_rdata_i;
      if (byte_i) begin
         be_o    = addr0_i ? BE_HI : BE_LO;
         wdata_o = {wdata_i[7:0], wdata_i[7:0]};
         rdata_o = {{8{selByte[7]}}, selByte};
      end
   end

endmodule

// File: rtl/lc3b_mem_ctrl.sv
// LC-3b memory interface stage: turns MAR/MDR word or byte accesses into a
// single handshaked word-wide memory cycle and returns R (ready) to control.
module lc3b_mem_ctrl
   import lc3b_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
)
(
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        req_i,
   input  logic        we_i,
   input  logic        byte_i,
   input  logic [15:0] addr_i,
   input  logic [15:0] wdata_i,
   output logic [15:0] rdata_o,
   output logic        ready_o,
   output logic        unaligned_o,
   output logic        timeout_o,
   output logic        mem_cs_o,
   output logic        mem_we_o,
   output logic [14:0] mem_addr_o,
   output logic [1:0]  mem_be_o,
   output logic [15:0] mem_wdata_o,
   input  logic [15:0] mem_rdata_i,
   input  logic        mem_ack_i
);

   localparam int              CW        = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]   WAIT_LAST = CW'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] waitCnt_q, waitCnt_d;
   logic          we_q, we_d;
   logic          byte_q, byte_d;
   logic          addr0_q, addr0_d;
   logic [15:0]   rdata_q, rdata_d;
   logic          ready_q, ready_d;
   logic          unaligned_q, unaligned_d;
   logic          timeout_q, timeout_d;
   logic          memCs_q, memCs_d;
   logic          memWe_q, memWe_d;
   logic [14:0]   memAddr_q, memAddr_d;
   logic [1:0]    memBe_q, memBe_d;
   logic [15:0]   memWdata_q, memWdata_d;

   logic          laneByte;
   logic          laneAddr0;
   logic [1:0]    laneBe;
   logic [15:0]   laneWdata;
   logic [15:0]   laneRdata;

   // The lane sees the live request while idle and the latched one afterwards
   assign laneByte  = (state_q == IDLE) ? byte_i    : byte_q;
   assign laneAddr0 = (state_q == IDLE) ? addr_i[0] : addr0_q;

   lc3b_byte_lane u_lane (
      .byte_i      (laneByte),
      .addr0_i     (laneAddr0),
      .wdata_i     (wdata_i),
      .mem_rdata_i (mem_rdata_i),
      .be_o        (laneBe),
      .wdata_o     (laneWdata),
      .rdata_o     (laneRdata)
   );

   // Next-state and registered-output logic for the IDLE/ACCESS/RESP sequence
   always_comb begin
      state_d     = state_q;
      waitCnt_d   = waitCnt_q;
      we_d        = we_q;
      byte_d      = byte_q;
      addr0_d     = addr0_q;
      rdata_d     = rdata_q;
      unaligned_d = 1'b0;
      timeout_d   = 1'b0;
      memWe_d     = memWe_q;
      memAddr_d   = memAddr_q;
      memBe_d     = memBe_q;
      memWdata_d  = memWdata_q;
      unique case (state_q)
         IDLE: begin
            if (req_i) begin
               we_d    = we_i;
               byte_d  = byte_i;
               addr0_d = addr_i[0];
               if (!byte_i && addr_i[0]) begin
                  state_d     = RESP;
                  unaligned_d = 1'b1;
                  rdata_d     = '0;
               end else begin
                  state_d    = ACCESS;
                  waitCnt_d  = '0;
                  memWe_d    = we_i;
                  memAddr_d  = addr_i[15:1];
                  memBe_d    = laneBe;
                  memWdata_d = laneWdata;
               end
            end
         end
         ACCESS: begin
            if (mem_ack_i) begin
               state_d = RESP;
               if (!we_q) begin
                  rdata_d = laneRdata;
               end
            end else if (waitCnt_q == WAIT_LAST) begin
               state_d   = RESP;
               timeout_d = 1'b1;
               rdata_d   = '0;
            end else begin
               waitCnt_d = waitCnt_q + CW'(1);
            end
            if (state_d != ACCESS) begin
               memWe_d    = 1'b0;
               memAddr_d  = '0;
               memBe_d    = '0;
               memWdata_d = '0;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      ready_d = (state_d == RESP);
      memCs_d = (state_d == ACCESS);
   end

   // State and output registers; reset aborts any cycle in flight at once
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= IDLE;
         waitCnt_q   <= '0;
         we_q        <= 1'b0;
         byte_q      <= 1'b0;
         addr0_q     <= 1'b0;
         rdata_q     <= '0;
         ready_q     <= 1'b0;
         unaligned_q <= 1'b0;
         timeout_q   <= 1'b0;
         memCs_q     <= 1'b0;
         memWe_q     <= 1'b0;
         memAddr_q   <= '0;
         memBe_q     <= '0;
         memWdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         waitCnt_q   <= waitCnt_d;
         we_q        <= we_d;
         byte_q      <= byte_d;
         addr0_q     <= addr0_d;
         rdata_q     <= rdata_d;
         ready_q     <= ready_d;
         unaligned_q <= unaligned_d;
         timeout_q   <= timeout_d;
         memCs_q     <= memCs_d;
         memWe_q     <= memWe_d;
         memAddr_q   <= memAddr_d;
         memBe_q     <= memBe_d;
         memWdata_q  <= memWdata_d;
      end
   end

   assign rdata_o     = rdata_q;
   assign ready_o     = ready_q;
   assign unaligned_o = unaligned_q;
   assign timeout_o   = timeout_q;
   assign mem_cs_o    = memCs_q;
   assign mem_we_o    = memWe_q;
   assign mem_addr_o  = memAddr_q;
   assign mem_be_o    = memBe_q;
   assign mem_wdata_o = memWdata_q;

endmodule
